// File: rtl/m_msg_engine.sv
// m_msg_engine: debounced send/clear buttons driving a byte-wise SPI frame exchange
// between a transmit buffer and a valid-tracked receive buffer.
module m_msg_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 64,
  parameter int ADDR_W       = 6,
  parameter int DEB_DIV      = 27000,
  parameter int DEB_LEN      = 6,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                  I_CLK,
  input  logic                  I_RESETN,
  input  logic                  i_btn_send,
  input  logic                  i_btn_clear,
  input  logic                  i_mode,
  input  logic [ADDR_W:0]       i_tx_len,
  input  logic                  i_tx_we,
  input  logic [ADDR_W-1:0]     i_tx_waddr,
  input  logic [DATA_WIDTH-1:0] i_tx_wdata,
  output logic                  o_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic                  i_busy,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_active,
  output logic [ADDR_W:0]       o_rx_count,
  output logic                  o_frame_done,
  output logic                  o_error
);
  localparam int PW = DEB_DIV > 1 ? $clog2(DEB_DIV) : 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [DEB_LEN:0] PRESS = {1'b0, {DEB_LEN{1'b1}}};

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, STORE, DONE} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         pre_q;
  logic                  tick;
  logic [DEB_LEN:0]      send_h_q, send_h_d, clr_h_q, clr_h_d;
  logic                  send_ev_q, clr_ev_q;
  logic [ADDR_W:0]       len_q, len_d, idx_q, idx_d, cnt_q, cnt_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d, rd_data_q;
  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
  logic                  rx_we;

  assign tick     = pre_q == PW'(DEB_DIV - 1);
  assign send_h_d = {send_h_q[DEB_LEN-1:0], i_btn_send};
  assign clr_h_d  = {clr_h_q[DEB_LEN-1:0], i_btn_clear};
  assign rx_we    = state_q == STORE && !clr_ev_q;

  assign o_start      = state_q == START && !clr_ev_q;
  assign o_active     = state_q != IDLE;
  assign o_frame_done = state_q == DONE;
  assign o_tx_data    = tx_data_q;
  assign o_rd_data    = rd_data_q;
  assign o_rx_count   = cnt_q;

  always_ff @(posedge I_CLK) begin
    if (i_tx_we) tx_mem[i_tx_waddr] <= i_tx_wdata;
    if (rx_we) rx_mem[idx_q[ADDR_W-1:0]] <= i_rx_data;
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    tmo_d     = tmo_q;
    tx_data_d = tx_data_q;
    o_error   = 1'b0;
    case (state_q)
      IDLE: if (send_ev_q && i_tx_len != '0) begin
        len_d   = i_tx_len;
        idx_d   = '0;
        cnt_d   = '0;
        valid_d = '0;
        state_d = LOAD;
      end
      LOAD: begin
        tx_data_d = tx_mem[idx_q[ADDR_W-1:0]];
        state_d   = START;
      end
      START: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (i_busy) state_d = WAIT_DONE;
        else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          o_error = 1'b1;
          state_d = IDLE;
        end else tmo_d = tmo_q + 1'b1;
      WAIT_DONE: if (!i_busy) state_d = STORE;
      STORE: begin
        valid_d[idx_q[ADDR_W-1:0]] = 1'b1;
        cnt_d = idx_q + 1'b1;
        if (idx_q == len_q - 1'b1) state_d = DONE;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD;
        end
      end
      DONE: if (i_mode) begin
        len_d = i_tx_len;
        if (i_tx_len != '0) begin
          idx_d   = '0;
          valid_d = '0;
          state_d = LOAD;
        end else state_d = IDLE;
      end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // clear outranks everything, including a timeout in the same clock
    if (clr_ev_q) begin
      state_d = IDLE;
      valid_d = '0;
      idx_d   = '0;
      cnt_d   = '0;
      o_error = 1'b0;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      send_h_q  <= '0;
      clr_h_q   <= '0;
      send_ev_q <= 1'b0;
      clr_ev_q  <= 1'b0;
      len_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= '0;
      tmo_q     <= '0;
      tx_data_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pre_q     <= tick ? '0 : pre_q + 1'b1;
      send_h_q  <= tick ? send_h_d : send_h_q;
      clr_h_q   <= tick ? clr_h_d : clr_h_q;
      send_ev_q <= tick && send_h_d == PRESS;
      clr_ev_q  <= tick && clr_h_d == PRESS;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      tmo_q     <= tmo_d;
      tx_data_q <= tx_data_d;
      rd_data_q <= valid_q[i_rd_addr] ? rx_mem[i_rd_addr] : '0;
    end
  end
endmodule

// File: tb/tb_m_msg_engine.sv
// tb_m_msg_engine: directed checks of debounce, frame exchange, continuous mode,
// busy timeout, clear abort and full-depth frames against an echo-plus-one SPI model.
module tb_m_msg_engine;
  localparam int DIV = 4;
  localparam int TMO = 20;

  logic       I_CLK = 1'b0, I_RESETN = 1'b0;
  logic       i_btn_send = 1'b0, i_btn_clear = 1'b0, i_mode = 1'b0;
  logic [6:0] i_tx_len = '0;
  logic       i_tx_we = 1'b0;
  logic [5:0] i_tx_waddr = '0, i_rd_addr = '0;
  logic [7:0] i_tx_wdata = '0, i_rx_data = '0;
  logic       i_busy = 1'b0;
  logic       o_start, o_active, o_frame_done, o_error;
  logic [7:0] o_tx_data, o_rd_data;
  logic [6:0] o_rx_count;

  int n_chk = 0, n_err = 0;
  int n_start = 0, n_done = 0, n_error = 0;
  int spi_len = 3, spi_cnt = 0;
  bit spi_en = 1'b1;

  always #5 I_CLK = ~I_CLK;

  m_msg_engine #(.DEB_DIV(DIV), .BUSY_TIMEOUT(TMO)) dut (
    .I_CLK(I_CLK), .I_RESETN(I_RESETN),
    .i_btn_send(i_btn_send), .i_btn_clear(i_btn_clear), .i_mode(i_mode),
    .i_tx_len(i_tx_len), .i_tx_we(i_tx_we), .i_tx_waddr(i_tx_waddr),
    .i_tx_wdata(i_tx_wdata), .o_start(o_start), .o_tx_data(o_tx_data),
    .i_busy(i_busy), .i_rx_data(i_rx_data), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_active(o_active), .o_rx_count(o_rx_count),
    .o_frame_done(o_frame_done), .o_error(o_error)
  );

  // SPI slave model: busy for spi_len clocks after o_start, echoes tx byte + 1
  always @(negedge I_CLK) begin
    if (o_start) n_start++;
    if (o_frame_done) n_done++;
    if (o_error) n_error++;
    i_rx_data = o_tx_data + 8'd1;
    if (!spi_en) begin
      spi_cnt = 0;
      i_busy  = 1'b0;
    end else if (o_start) begin
      spi_cnt = spi_len;
      i_busy  = 1'b0;
    end else if (spi_cnt != 0) begin
      spi_cnt--;
      i_busy = 1'b1;
    end else i_busy = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    i_tx_we = 1'b1; i_tx_waddr = a; i_tx_wdata = d;
    @(negedge I_CLK);
    i_tx_we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [7:0] exp);
    i_rd_addr = a;
    @(negedge I_CLK);
    check(tag, o_rd_data, exp);
  endtask

  task automatic press_send();
    i_btn_send = 1'b1;
    repeat (40) @(negedge I_CLK);
    i_btn_send = 1'b0;
  endtask

  initial begin
    int s0, d0, e0, k, frames, act_low;
    logic seen, started;
    repeat (3) @(negedge I_CLK);
    I_RESETN = 1'b1;
    @(negedge I_CLK);
    check("rst_start", o_start, 0);
    check("rst_active", o_active, 0);
    check("rst_count", o_rx_count, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_error", o_error, 0);
    check("rst_txdata", o_tx_data, 0);
    check("rst_rddata", o_rd_data, 0);
    for (int i = 0; i < 64; i++) wr(6'(i), i < 4 ? 8'(8'h41 + i) : 8'(i));

    // zero-length send is ignored
    i_tx_len = 7'd0;
    press_send();
    repeat (20) @(negedge I_CLK);
    check("len0_starts", n_start, 0);
    check("len0_active", o_active, 0);

    // single byte: o_start two clocks after the debounced event
    i_tx_len = 7'd1;
    i_btn_send = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge I_CLK);
      seen = dut.send_ev_q;
    end
    check("ev_seen", seen, 1);
    @(negedge I_CLK);
    check("start_t1", o_start, 0);
    @(negedge I_CLK);
    check("start_t2", o_start, 1);
    check("txd0", o_tx_data, 8'h41);
    repeat (40) @(negedge I_CLK);
    i_btn_send = 1'b0;
    repeat (20) @(negedge I_CLK);
    check("t1_starts", n_start, 1);
    check("t1_done", n_done, 1);
    check("t1_count", o_rx_count, 1);
    rd_chk("t1_rd0", 0, 8'h42);

    // four-byte frame, single shot
    i_tx_len = 7'd4;
    s0 = n_start; d0 = n_done;
    press_send();
    repeat (80) @(negedge I_CLK);
    check("t2_starts", n_start - s0, 4);
    check("t2_done", n_done - d0, 1);
    check("t2_count", o_rx_count, 4);
    rd_chk("t2_rd0", 0, 8'h42);
    rd_chk("t2_rd1", 1, 8'h43);
    rd_chk("t2_rd2", 2, 8'h44);
    rd_chk("t2_rd3", 3, 8'h45);
    rd_chk("t2_rd4", 4, 8'h00);

    // continuous mode for three frames
    i_mode = 1'b1;
    s0 = n_start; frames = 0; act_low = 0; started = 1'b0;
    i_btn_send = 1'b1;
    for (int i = 0; i < 600 && frames < 3; i++) begin
      @(negedge I_CLK);
      if (i == 40) i_btn_send = 1'b0;
      if (o_start) started = 1'b1;
      if (started && !o_active) act_low++;
      if (o_frame_done) begin
        frames++;
        if (frames == 3) i_mode = 1'b0;
      end
    end
    i_btn_send = 1'b0;
    @(negedge I_CLK);
    check("t3_frames", frames, 3);
    check("t3_starts", n_start - s0, 12);
    check("t3_act_low", act_low, 0);
    check("t3_idle", o_active, 0);
    repeat (30) @(negedge I_CLK);

    // busy never rises: timeout
    spi_en = 1'b0;
    i_tx_len = 7'd1;
    e0 = n_error; d0 = n_done;
    i_btn_send = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge I_CLK);
      seen = o_start;
    end
    check("t4_start", seen, 1);
    k = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge I_CLK);
      k++;
      seen = o_error;
    end
    check("t4_err_seen", seen, 1);
    check("t4_latency", k, TMO);
    @(negedge I_CLK);
    check("t4_idle", o_active, 0);
    i_btn_send = 1'b0;
    repeat (40) @(negedge I_CLK);
    check("t4_err_count", n_error - e0, 1);
    check("t4_no_done", n_done - d0, 0);
    check("t4_count", o_rx_count, 0);

    // clear during WAIT_DONE of the second byte
    spi_en = 1'b1; spi_len = 60;
    i_tx_len = 7'd4;
    s0 = n_start; d0 = n_done;
    press_send();
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge I_CLK);
      seen = (n_start - s0 == 2) && i_busy;
    end
    check("t5_byte2", seen, 1);
    check("t5_count1", o_rx_count, 1);
    i_btn_clear = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge I_CLK);
      seen = dut.clr_ev_q;
    end
    check("t5_clr_seen", seen, 1);
    check("t5_in_wait", i_busy, 1);
    @(negedge I_CLK);
    check("t5_idle", o_active, 0);
    check("t5_count0", o_rx_count, 0);
    i_btn_clear = 1'b0;
    repeat (80) @(negedge I_CLK);
    for (int i = 0; i < 4; i++) rd_chk("t5_rd", 6'(i), 8'h00);
    check("t5_no_done", n_done - d0, 0);

    // full-depth frame
    spi_len = 2;
    i_tx_len = 7'd64;
    s0 = n_start; d0 = n_done;
    press_send();
    for (int i = 0; i < 1500 && n_done == d0; i++) @(negedge I_CLK);
    @(negedge I_CLK);
    check("t6_done", n_done - d0, 1);
    check("t6_starts", n_start - s0, 64);
    check("t6_count", o_rx_count, 64);
    rd_chk("t6_rd0", 0, 8'h42);
    rd_chk("t6_rd10", 10, 8'h0b);
    rd_chk("t6_rd63", 63, 8'h40);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
